// File: rtl/bitstream_unpacker_pkg.sv
// Shared helpers for the bitstream unpacker: ceil-log2 for port sizing and a
// width-limited bit reverse used for MSB-first stream ordering.
package bitstream_unpacker_pkg;

  localparam int REV_MAX_W = 64;

  // ceil(log2(value)); clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Reverses the low `width` bits of value; bits at and above `width` return 0.
  function automatic logic [REV_MAX_W-1:0] bit_reverse(input logic [REV_MAX_W-1:0] value,
                                                        input int width);
    logic [REV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < REV_MAX_W; i++) begin
      if (i < width) r[i] = value[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_funnel_shifter.sv
// Right-shifts the bit buffer by the retired bit count and OR-inserts a new word
// at an arbitrary bit offset (the fill level after retirement).
module bit_funnel_shifter #(
  parameter int BUFFER_WIDTH = 32,
  parameter int WIDTH_IN     = 8,
  parameter int SHIFT_W      = 4,
  parameter int OFFSET_W     = 7
) (
  input  logic [BUFFER_WIDTH-1:0] buf_in,
  input  logic [SHIFT_W-1:0]      shift,
  input  logic [WIDTH_IN-1:0]     word,
  input  logic                    insert,
  input  logic [OFFSET_W-1:0]     offset,
  output logic [BUFFER_WIDTH-1:0] buf_out
);

  logic [BUFFER_WIDTH-1:0] shifted;
  logic [BUFFER_WIDTH-1:0] word_ext;

  // bits above the offset are already zero, so OR is a safe insert
  always_comb begin
    shifted  = buf_in >> shift;
    word_ext = '0;
    word_ext[WIDTH_IN-1:0] = word;
    buf_out  = shifted;
    if (insert) buf_out = shifted | (word_ext << offset);
  end

endmodule

// File: rtl/bitstream_unpacker.sv
// Bit-granular FIFO front-end for variable-length decoders: word pushes with
// valid/ready, 0..WIDTH_OUT bit retirement per cycle, sticky overpop error.
module bitstream_unpacker
  import bitstream_unpacker_pkg::*;
#(
  parameter  int WIDTH_IN     = 8,
  parameter  int WIDTH_OUT    = 8,
  parameter  int BUFFER_WIDTH = 32,
  parameter  int MSB_FIRST    = 0,
  localparam int POP_W        = clog2(WIDTH_OUT + 1),
  localparam int LVL_W        = clog2(BUFFER_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_IN-1:0]  d,
  input  logic [POP_W-1:0]     pop,
  output logic [WIDTH_OUT-1:0] q,
  output logic [LVL_W-1:0]     level,
  output logic                 q_full,
  output logic                 err
);

  localparam int LX = LVL_W + 1;

  logic [BUFFER_WIDTH-1:0] buffer;
  logic [BUFFER_WIDTH-1:0] buffer_shifted;
  logic [LX-1:0]           level_x;
  logic [LX-1:0]           pop_x;
  logic [LX-1:0]           pop_eff_x;
  logic [LX-1:0]           level_after_pop;
  logic [LX-1:0]           level_next;
  logic [POP_W-1:0]        pop_eff;
  logic                    pop_ok;
  logic                    pop_bad;
  logic                    push;
  logic [WIDTH_IN-1:0]     d_ord;
  logic [WIDTH_OUT-1:0]    q_raw;

  // level math one bit wider so BUFFER_WIDTH = 2^n cannot wrap
  assign level_x   = LX'(level);
  assign pop_x     = LX'(pop);
  assign in_ready  = level_x <= LX'(BUFFER_WIDTH - WIDTH_IN);
  assign q_full    = level_x >= LX'(WIDTH_OUT);

  assign pop_ok    = (pop_x <= level_x) && (pop_x <= LX'(WIDTH_OUT));
  assign pop_bad   = (pop != '0) && !pop_ok && !flush;
  assign pop_eff   = pop_ok ? pop : '0;
  assign pop_eff_x = LX'(pop_eff);
  assign push      = in_valid && in_ready && !flush;

  assign level_after_pop = level_x - pop_eff_x;
  assign level_next      = flush ? '0 : (level_after_pop + (push ? LX'(WIDTH_IN) : LX'(0)));

  // buffer always holds bit 0 as the next stream bit; MSB-first order is mapped at the edges
  assign d_ord = (MSB_FIRST != 0) ? WIDTH_IN'(bit_reverse(REV_MAX_W'(d), WIDTH_IN)) : d;
  assign q_raw = buffer[WIDTH_OUT-1:0];
  assign q     = (MSB_FIRST != 0) ? WIDTH_OUT'(bit_reverse(REV_MAX_W'(q_raw), WIDTH_OUT)) : q_raw;

  bit_funnel_shifter #(
    .BUFFER_WIDTH (BUFFER_WIDTH),
    .WIDTH_IN     (WIDTH_IN),
    .SHIFT_W      (POP_W),
    .OFFSET_W     (LX)
  ) u_funnel (
    .buf_in  (buffer),
    .shift   (pop_eff),
    .word    (d_ord),
    .insert  (push),
    .offset  (level_after_pop),
    .buf_out (buffer_shifted)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buffer <= '0;
      level  <= '0;
      err    <= 1'b0;
    end else begin
      buffer <= flush ? '0 : buffer_shifted;
      level  <= level_next[LVL_W-1:0];
      if (pop_bad) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) assert (level_next <= LX'(BUFFER_WIDTH));
  end

endmodule
